imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage.
- Classifies a RISC-V instruction word by opcode into a format: R, I, S, B, U, J or illegal.
- Builds the architecturally correct sign-extended XLEN-bit immediate.
- Delivers the result through a 2-entry skid buffer with valid/ready on both sides.
- Sits between fetch/IF-ID and register read. o_in_ready is registered, so no combinational ready path crosses the stage.

---
 rtl/imm_gen_pipe_pkg.sv | 27 ++
 rtl/imm_decode.sv | 57 +++++
 rtl/imm_gen_pipe.sv | 95 +++++++++
 tb/tb_imm_gen_pipe.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and RISC-V opcode constants for the decode-stage immediate generator.
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } imm_fmt_t;

    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_32     = 7'b0111011;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classifier and sign-extended immediate builder.
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic [ILEN-1:0] i_instr,
    output logic [XLEN-1:0] o_imm,
    output imm_fmt_t        o_fmt,
    output logic            o_illegal
);

    logic [31:0] imm32;

    // Every legal opcode ends in 2'b11, so a bad low pair simply misses all case items.
    always_comb begin
        imm32     = '0;
        o_fmt     = FMT_ILL;
        o_illegal = 1'b1;
        unique case (i_instr[6:0])
            LOAD, OP_IMM, OP_IMM_32, JALR, SYSTEM: begin
                o_fmt     = FMT_I;
                o_illegal = 1'b0;
                imm32     = {{20{i_instr[31]}}, i_instr[31:20]};
            end
            STORE: begin
                o_fmt     = FMT_S;
                o_illegal = 1'b0;
                imm32     = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            end
            BRANCH: begin
                o_fmt     = FMT_B;
                o_illegal = 1'b0;
                imm32     = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                o_fmt     = FMT_U;
                o_illegal = 1'b0;
                imm32     = {i_instr[31:12], 12'b0};
            end
            JAL: begin
                o_fmt     = FMT_J;
                o_illegal = 1'b0;
                imm32     = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            end
            OP, OP_32: begin
                o_fmt     = FMT_R;
                o_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode feeds a 2-entry skid buffer with a registered in_ready.
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [ILEN-1:0] i_instr,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_imm,
    output logic [2:0]      o_fmt,
    output logic            o_illegal
);

    if (ILEN != 32) begin : g_bad_ilen
        $error("imm_gen_pipe: ILEN must be 32");
    end
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_t        fmt;
        logic            illegal;
    } imm_entry_t;

    imm_entry_t dec_entry;
    imm_entry_t head_q, head_d;
    imm_entry_t tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    imm_decode #(
        .XLEN(XLEN),
        .ILEN(ILEN)
    ) u_decode (
        .i_instr  (i_instr),
        .o_imm    (dec_entry.imm),
        .o_fmt    (dec_entry.fmt),
        .o_illegal(dec_entry.illegal)
    );

    assign push = i_in_valid & in_ready_q;
    assign pop  = (count_q != 2'd0) & i_out_ready;

    // Pop shifts tail into head first, then a push lands in the first free slot.
    // The tail is zeroed when vacated so an empty buffer shows all-zero outputs.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            head_d  = tail_q;
            tail_d  = '0;
            count_d = count_q - 2'd1;
        end
        if (push) begin
            if (count_d == 2'd0) begin
                head_d = dec_entry;
            end else begin
                tail_d = dec_entry;
            end
            count_d = count_d + 2'd1;
        end
        in_ready_d = (count_d < 2'd2);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign o_in_ready  = in_ready_q;
    assign o_out_valid = (count_q != 2'd0);
    assign o_imm       = head_q.imm;
    assign o_fmt       = head_q.fmt;
    assign o_illegal   = head_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: vector table stream plus backpressure and reset sequences.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic        clock;
    logic        rstN;
    logic        inValid;
    logic [31:0] instr;
    logic        outReady;

    logic        inReady, outValid, illegal;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        inReady32, outValid32, illegal32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [31:0] instr;
        imm_fmt_t    fmt;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[14];

    imm_gen_pipe #(.XLEN(64), .ILEN(32)) u_dut (
        .i_clk      (clock),
        .i_rst_n    (rstN),
        .i_in_valid (inValid),
        .o_in_ready (inReady),
        .i_instr    (instr),
        .o_out_valid(outValid),
        .i_out_ready(outReady),
        .o_imm      (imm),
        .o_fmt      (fmt),
        .o_illegal  (illegal)
    );

    imm_gen_pipe #(.XLEN(32), .ILEN(32)) u_dut32 (
        .i_clk      (clock),
        .i_rst_n    (rstN),
        .i_in_valid (inValid),
        .o_in_ready (inReady32),
        .i_instr    (instr),
        .o_out_valid(outValid32),
        .i_out_ready(outReady),
        .o_imm      (imm32),
        .o_fmt      (fmt32),
        .o_illegal  (illegal32)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus(input logic valid, input logic [31:0] word, input logic ready);
        inValid  = valid;
        instr    = word;
        outReady = ready;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic checkHead(input string name, input vec_t v);
        checkOutput({name, " valid"},   64'(outValid), 64'd1);
        checkOutput({name, " fmt"},     64'(fmt),      64'(v.fmt));
        checkOutput({name, " imm"},     imm,           v.imm);
        checkOutput({name, " illegal"}, 64'(illegal),  64'(v.ill));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"ADDI",   32'hFFF00093, FMT_I,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1]  = '{"SD",     32'hFE20BC23, FMT_S,   64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vecs[2]  = '{"BEQ",    32'hFE000EE3, FMT_B,   64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[3]  = '{"LUI",    32'h800000B7, FMT_U,   64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[4]  = '{"JAL",    32'h0010006F, FMT_J,   64'h0000_0000_0000_0800, 1'b0};
        vecs[5]  = '{"ILL7F",  32'h0000007F, FMT_ILL, 64'h0,                   1'b1};
        vecs[6]  = '{"ADD",    32'h002081B3, FMT_R,   64'h0,                   1'b0};
        vecs[7]  = '{"AUIPC",  32'h12345017, FMT_U,   64'h0000_0000_1234_5000, 1'b0};
        vecs[8]  = '{"LW",     32'h00812083, FMT_I,   64'h8,                   1'b0};
        vecs[9]  = '{"ADDIW",  32'h8000001B, FMT_I,   64'hFFFF_FFFF_FFFF_F800, 1'b0};
        vecs[10] = '{"BNE",    32'h00001463, FMT_B,   64'h8,                   1'b0};
        vecs[11] = '{"JALNEG", 32'hFFDFF06F, FMT_J,   64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[12] = '{"LOWBAD", 32'hFFF00010, FMT_ILL, 64'h0,                   1'b1};
        vecs[13] = '{"ECALL",  32'h00000073, FMT_I,   64'h0,                   1'b0};

        // Reset with a valid instruction presented: it must be ignored.
        rstN = 1'b0;
        applyStimulus(1'b1, 32'hFFF00093, 1'b1);
        repeat (2) tick();
        checkOutput("rst out_valid", 64'(outValid),  64'd0);
        checkOutput("rst in_ready",  64'(inReady),   64'd0);
        checkOutput("rst imm",       imm,            64'd0);
        checkOutput("rst fmt",       64'(fmt),       64'(FMT_R));
        checkOutput("rst illegal",   64'(illegal),   64'd0);
        checkOutput("rst in_ready32",64'(inReady32), 64'd0);

        rstN = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("post-rst in_ready",  64'(inReady),  64'd1);
        checkOutput("post-rst out_valid", 64'(outValid), 64'd0);

        // Stream the whole table one per cycle with the consumer always ready.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 1'b1);
            checkOutput({vecs[i].name, " in_ready"}, 64'(inReady), 64'd1);
            tick();
            checkHead(vecs[i].name, vecs[i]);
            checkOutput({vecs[i].name, " imm32"}, 64'(imm32), 64'(vecs[i].imm[31:0]));
            checkOutput({vecs[i].name, " fmt32"}, 64'(fmt32), 64'(vecs[i].fmt));
            checkOutput({vecs[i].name, " valid32"}, 64'(outValid32), 64'd1);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("drain out_valid", 64'(outValid), 64'd0);
        checkOutput("drain illegal32", 64'(illegal32), 64'd0);

        // Backpressure: three offered, two accepted, head held stable.
        applyStimulus(1'b1, vecs[1].instr, 1'b0);
        tick();
        checkHead("bp first", vecs[1]);
        checkOutput("bp in_ready after 1", 64'(inReady), 64'd1);
        applyStimulus(1'b1, vecs[2].instr, 1'b0);
        tick();
        checkHead("bp hold A", vecs[1]);
        checkOutput("bp in_ready after 2", 64'(inReady), 64'd0);
        applyStimulus(1'b1, vecs[3].instr, 1'b0);
        repeat (2) begin
            tick();
            checkHead("bp stall", vecs[1]);
            checkOutput("bp in_ready stall", 64'(inReady), 64'd0);
        end
        applyStimulus(1'b1, vecs[3].instr, 1'b1);
        tick();
        checkHead("bp pop->B", vecs[2]);
        checkOutput("bp in_ready reopen", 64'(inReady), 64'd1);
        tick();
        checkHead("bp pop->C", vecs[3]);
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("bp empty", 64'(outValid), 64'd0);
        checkOutput("bp in_ready end", 64'(inReady), 64'd1);

        // Reset mid-operation with a full buffer: entries must vanish.
        applyStimulus(1'b1, vecs[4].instr, 1'b0);
        tick();
        applyStimulus(1'b1, vecs[5].instr, 1'b0);
        tick();
        checkOutput("mid full in_ready", 64'(inReady), 64'd0);
        rstN = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1);
        tick();
        checkOutput("mid rst out_valid", 64'(outValid), 64'd0);
        checkOutput("mid rst imm",       imm,            64'd0);
        rstN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("mid rst no emit", 64'(outValid), 64'd0);
        end
        checkOutput("mid rst in_ready", 64'(inReady), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
